udp_rx: RTL and testbench

- Transport-layer receive stage directly downstream of the IPv4 RX stage.
- Consumes the IPv4 payload stream, parses the 8-byte UDP header and filters on destination port and length sanity.
- Forwards matching UDP payload bytes to the application with an end-of-datagram marker.
- Discards non-matching, malformed, IP-checksum-failed or cancelled datagrams without emitting payload.

---
 rtl/udp_rx_if.sv | 29 ++
 rtl/udp_rx.sv | 168 ++++++++++++++++
 tb/tb_udp_rx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/udp_rx_if.sv
// UDP RX stream bundle: IPv4 payload stream in, UDP payload stream out.
// master = upstream/driver side, slave = udp_rx side.
interface udp_rx_if #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 2
);
  logic              valid_i;
  logic              cancel_i;
  logic [DATA_W-1:0] data_i;
  logic [LEN_W-1:0]  len_i;
  logic              ip_cs_err_i;

  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic [LEN_W-1:0]  len_o;
  logic              last_o;
  logic              cancel_o;
  logic              len_err_o;

  modport master (
    output valid_i, cancel_i, data_i, len_i, ip_cs_err_i,
    input  valid_o, data_o, len_o, last_o, cancel_o, len_err_o
  );

  modport slave (
    input  valid_i, cancel_i, data_i, len_i, ip_cs_err_i,
    output valid_o, data_o, len_o, last_o, cancel_o, len_err_o
  );
endinterface

// File: rtl/udp_rx.sv
// UDP receive stage: parses the 8-byte UDP header from the IPv4 payload
// stream, filters on destination port and length sanity, and forwards
// matching payload bytes with zero latency and an end-of-datagram marker.
// Optional source-port filter: define UDP_RX_SRC_PORT_MATCH_EN.
module udp_rx #(
  parameter int                DATA_W   = 16,
  parameter int                LEN_W    = 2,
  parameter int                PORT_W   = 16,
  parameter logic [PORT_W-1:0] DST_PORT = 16'd18000
`ifdef UDP_RX_SRC_PORT_MATCH_EN
  ,
  parameter logic [PORT_W-1:0] SRC_PORT = 16'd0
`endif
) (
  input logic     clk,
  input logic     nreset,
  udp_rx_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    HEAD = 4'b0010,
    DATA = 4'b0100,
    DROP = 4'b1000
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [1:0]    hidx_q, hidx_d;
  logic [15:0]   udp_len_q, udp_len_d;
  logic          len_lat_q, len_lat_d;
  logic          drop_q, drop_d;
  logic          emit_q, emit_d;

  logic [DATA_W-1:0] word;
  logic [PORT_W-1:0] field;
  logic [15:0]       remaining;
  logic [15:0]       len_ext;
  logic              src_bad;
  logic              valid_c, last_c, cancel_c, len_err_c;
  logic [LEN_W-1:0]  len_c;

  assign word    = bus.data_i;
  assign field   = {word[7:0], word[15:8]};
  assign len_ext = 16'(bus.len_i);

  // Source-port mismatch on header word 0 (only with the filter built in)
`ifdef UDP_RX_SRC_PORT_MATCH_EN
  always_comb src_bad = (field != SRC_PORT);
`else
  always_comb src_bad = 1'b0;
`endif

  // State and header/counter registers
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hidx_q    <= '0;
      udp_len_q <= '0;
      len_lat_q <= 1'b0;
      drop_q    <= 1'b0;
      emit_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hidx_q    <= hidx_d;
      udp_len_q <= udp_len_d;
      len_lat_q <= len_lat_d;
      drop_q    <= drop_d;
      emit_q    <= emit_d;
    end
  end

  // Next-state, header parsing and payload passthrough
  always_comb begin
    state_d   = state_q;
    cnt_d     = bus.valid_i ? (cnt_q + len_ext) : cnt_q;
    hidx_d    = hidx_q;
    udp_len_d = udp_len_q;
    len_lat_d = len_lat_q;
    drop_d    = drop_q;
    emit_d    = emit_q;
    valid_c   = 1'b0;
    last_c    = 1'b0;
    cancel_c  = 1'b0;
    len_err_c = 1'b0;
    len_c     = bus.len_i;
    remaining = udp_len_q - cnt_q;

    case (state_q)
      IDLE: begin
        // Counter restarts from the accepted word rather than accumulating,
        // so a datagram may start in the first IDLE cycle after the previous one.
        cnt_d     = '0;
        hidx_d    = 2'd1;
        len_lat_d = 1'b0;
        drop_d    = 1'b0;
        emit_d    = 1'b0;
        if (bus.valid_i && !bus.cancel_i) begin
          state_d = HEAD;
          cnt_d   = len_ext;
          drop_d  = bus.ip_cs_err_i | src_bad;
        end
      end

      HEAD: begin
        if (bus.valid_i) begin
          hidx_d = hidx_q + 2'd1;
          case (hidx_q)
            2'd1: if (field != DST_PORT) drop_d = 1'b1;
            2'd2: begin
              udp_len_d = 16'(field);
              len_lat_d = 1'b1;
              if (field < 16'd8) begin
                len_err_c = 1'b1;
                drop_d    = 1'b1;
              end
            end
            2'd3: begin
              if (drop_q)                  state_d = DROP;
              else if (udp_len_q == 16'd8) state_d = IDLE;
              else                         state_d = DATA;
            end
            default: ;
          endcase
        end
      end

      DATA: begin
        cancel_c = bus.cancel_i & emit_q;
        if (bus.valid_i && !bus.cancel_i) begin
          valid_c = 1'b1;
          emit_d  = 1'b1;
          if (remaining <= len_ext) begin
            len_c   = remaining[LEN_W-1:0];
            last_c  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      DROP: begin
        if (len_lat_q && (udp_len_q >= 16'd8)) begin
          if (cnt_d >= udp_len_q) state_d = IDLE;
        end else if (!bus.valid_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (bus.cancel_i) state_d = IDLE;
  end

  // Outputs are forced low while reset is held so a mid-datagram reset
  // produces no stray payload or cancel indication.
  always_comb begin
    bus.valid_o   = valid_c   & nreset;
    bus.last_o    = last_c    & nreset;
    bus.cancel_o  = cancel_c  & nreset;
    bus.len_err_o = len_err_c & nreset;
    bus.len_o     = len_c;
    bus.data_o    = word;
  end

endmodule

// File: tb/tb_udp_rx.sv
// Directed, table-driven bench for udp_rx.
module tb_udp_rx;

  logic clk;
  logic nreset;

  udp_rx_if #(.DATA_W(16), .LEN_W(2)) bus ();

  udp_rx #(
    .DATA_W  (16),
    .LEN_W   (2),
    .PORT_W  (16),
    .DST_PORT(16'd18000)
  ) dut (
    .clk   (clk),
    .nreset(nreset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        c;
    logic [15:0] d;
    logic [1:0]  l;
    logic        cs;
    logic        ev;
    logic        elast;
    logic        ecanc;
    logic        elerr;
    logic [1:0]  elen;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_checks;
  int unsigned n_fail;

  function automatic logic [15:0] sw(input logic [15:0] x);
    return {x[7:0], x[15:8]};
  endfunction

  task automatic add(input logic v, input logic c, input logic [15:0] d,
                     input logic [1:0] l, input logic cs, input logic ev,
                     input logic elast, input logic ecanc, input logic elerr,
                     input logic [1:0] elen);
    vec_t t;
    t.v = v; t.c = c; t.d = d; t.l = l; t.cs = cs;
    t.ev = ev; t.elast = elast; t.ecanc = ecanc; t.elerr = elerr; t.elen = elen;
    vecs.push_back(t);
  endtask

  // header word with no output expected
  task automatic hw(input logic [15:0] field, input logic cs);
    add(1'b1, 1'b0, sw(field), 2'd2, cs, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic idle();
    add(1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic [15:0] d,
                       input logic [1:0] l, input logic cs);
    @(negedge clk);
    bus.valid_i     = v;
    bus.cancel_i    = c;
    bus.data_i      = d;
    bus.len_i       = l;
    bus.ip_cs_err_i = cs;
    #2;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nreset   = 1'b0;
    bus.valid_i = 1'b0; bus.cancel_i = 1'b0; bus.data_i = '0;
    bus.len_i = 2'd2; bus.ip_cs_err_i = 1'b0;

    // Test 1: 5 payload bytes, last word carries one trailing IP byte
    hw(16'd1234, 1'b0); hw(16'd18000, 1'b0); hw(16'd13, 1'b0); hw(16'h0000, 1'b0);
    add(1, 0, 16'hBBAA, 2'd2, 0, 1, 0, 0, 0, 2'd2);
    add(1, 0, 16'hDDCC, 2'd2, 0, 1, 0, 0, 0, 2'd2);
    add(1, 0, 16'h11EE, 2'd2, 0, 1, 1, 0, 0, 2'd1);
    idle();
    // Test 2: wrong dst port, 6 words dropped, then matching datagram right after
    hw(16'd1234, 1'b0); hw(16'd18001, 1'b0); hw(16'd12, 1'b0); hw(16'h0000, 1'b0);
    hw(16'h1111, 1'b0); hw(16'h2222, 1'b0);
    hw(16'd1234, 1'b0); hw(16'd18000, 1'b0); hw(16'd10, 1'b0); hw(16'h0000, 1'b0);
    add(1, 0, 16'h3412, 2'd2, 0, 1, 1, 0, 0, 2'd2);
    idle();
    // Test 3: IP checksum error on word 0
    hw(16'd1234, 1'b1); hw(16'd18000, 1'b0); hw(16'd10, 1'b0); hw(16'h0000, 1'b0);
    hw(16'h5566, 1'b0);
    idle();
    // Test 4: length 6 -> len_err pulse on word 2
    hw(16'd1234, 1'b0); hw(16'd18000, 1'b0);
    add(1, 0, sw(16'd6), 2'd2, 0, 0, 0, 0, 1, 2'd0);
    hw(16'h0000, 1'b0);
    idle(); idle();
    // Test 5: cancel on 2nd payload word of a 20-byte payload
    hw(16'd1234, 1'b0); hw(16'd18000, 1'b0); hw(16'd28, 1'b0); hw(16'h0000, 1'b0);
    add(1, 0, 16'h0201, 2'd2, 0, 1, 0, 0, 0, 2'd2);
    add(1, 1, 16'h0403, 2'd2, 0, 0, 0, 1, 0, 2'd0);
    hw(16'h0605, 1'b0);                                   // IDLE: taken as word 0
    add(0, 1, 16'h0000, 2'd2, 0, 0, 0, 0, 0, 2'd0);       // silent cancel in HEAD
    idle();
    // Test 6: empty datagram then back-to-back 10-byte datagram;
    // checksum error flag on word 1 must be ignored
    hw(16'd1234, 1'b0); hw(16'd18000, 1'b0); hw(16'd8, 1'b0); hw(16'h0000, 1'b0);
    hw(16'd1234, 1'b0); hw(16'd18000, 1'b1); hw(16'd10, 1'b0); hw(16'h0000, 1'b0);
    add(1, 0, 16'h7788, 2'd2, 0, 1, 1, 0, 0, 2'd2);
    idle();
    // cancel coinciding with the last word: cancel wins
    hw(16'd1234, 1'b0); hw(16'd18000, 1'b0); hw(16'd12, 1'b0); hw(16'h0000, 1'b0);
    add(1, 0, 16'hA1A0, 2'd2, 0, 1, 0, 0, 0, 2'd2);
    add(1, 1, 16'hA3A2, 2'd2, 0, 0, 0, 1, 0, 2'd0);
    idle();

    // Reset state, with valid_i held high during reset
    drive(1'b1, 1'b0, 16'hFFFF, 2'd2, 1'b0);
    chk("reset_valid", 16'(bus.valid_o), 16'd0);
    chk("reset_last", 16'(bus.last_o), 16'd0);
    chk("reset_cancel", 16'(bus.cancel_o), 16'd0);
    chk("reset_lenerr", 16'(bus.len_err_o), 16'd0);
    drive(1'b0, 1'b0, 16'h0000, 2'd2, 1'b0);
    @(negedge clk);
    nreset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].c, vecs[i].d, vecs[i].l, vecs[i].cs);
      chk($sformatf("v%0d_valid", i), 16'(bus.valid_o), 16'(vecs[i].ev));
      chk($sformatf("v%0d_last", i), 16'(bus.last_o), 16'(vecs[i].elast));
      chk($sformatf("v%0d_cancel", i), 16'(bus.cancel_o), 16'(vecs[i].ecanc));
      chk($sformatf("v%0d_lenerr", i), 16'(bus.len_err_o), 16'(vecs[i].elerr));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_len", i), 16'(bus.len_o), 16'(vecs[i].elen));
        chk($sformatf("v%0d_data", i), bus.data_o, vecs[i].d);
      end
    end

    // Reset in the middle of a datagram: no output, no cancel_o, back in IDLE
    drive(1'b1, 1'b0, sw(16'd1234), 2'd2, 1'b0);
    drive(1'b1, 1'b0, sw(16'd18000), 2'd2, 1'b0);
    drive(1'b1, 1'b0, sw(16'd14), 2'd2, 1'b0);
    drive(1'b1, 1'b0, 16'h0000, 2'd2, 1'b0);
    drive(1'b1, 1'b0, 16'hC1C0, 2'd2, 1'b0);
    chk("mid_pre_valid", 16'(bus.valid_o), 16'd1);
    nreset = 1'b0;
    drive(1'b1, 1'b1, 16'hC3C2, 2'd2, 1'b0);
    chk("mid_rst_valid", 16'(bus.valid_o), 16'd0);
    chk("mid_rst_cancel", 16'(bus.cancel_o), 16'd0);
    @(negedge clk);
    nreset = 1'b1;
    drive(1'b1, 1'b0, 16'hC5C4, 2'd2, 1'b0);
    chk("post_rst_idle", 16'(bus.valid_o), 16'd0);
    drive(1'b0, 1'b1, 16'h0000, 2'd2, 1'b0);
    chk("post_rst_cancel", 16'(bus.cancel_o), 16'd0);
    drive(1'b0, 1'b0, 16'h0000, 2'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
